fifo_serial_tx: RTL
===================

# fifo_serial_tx

Drain stage that sits directly downstream of `sync_fifo`: it pops 8-bit words from the FIFO read port and transmits each one as an asynchronous serial frame. Each frame is one start bit (0), `WIDTH` data bits LSB-first, and one stop bit (1), at a fixed clocks-per-bit rate. It provides the FIFO's consumer side and the design's serial output line.

## Interface
- `WIDTH`, 8, data word width; must match the FIFO width.
- `CLKS_PER_BIT`, 4, clock cycles per serial bit; legal range ≥ 2.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  enables starting new frames; sampled only in IDLE.
- `empty`  in  1  FIFO empty flag.
- `fifo_data`  in  WIDTH  FIFO `data_out`; valid the cycle after `read_en` was high.
- `read_en`  out  1  FIFO pop strobe; registered, exactly one cycle per frame.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high from READ through STOP inclusive.
- `done`  out  1  one-cycle pulse on the edge that ends a stop bit.

## Operation
- Reset values: `read_en`=0, `tx`=1, `busy`=0, `done`=0, state=IDLE, all counters 0, shift register 0.
- States: IDLE, READ, LOAD, START, DATA, STOP.
- IDLE: on an edge with `en`=1 and `empty`=0, go to READ and set `read_en`=1 and `busy`=1. Otherwise remain in IDLE.
- READ: lasts one cycle. Next edge clears `read_en` and goes to LOAD.
- LOAD: lasts one cycle. Next edge captures `fifo_data` into the shift register, drives `tx`=0, clears the baud counter and goes to START.
- START: `tx`=0 for CLKS_PER_BIT cycles. Then drive `tx`=shift[0], clear the bit counter and go to DATA.
- DATA: each bit is held CLKS_PER_BIT cycles. At each bit end the shift register shifts right and the bit counter increments. After bit WIDTH-1, drive `tx`=1 and go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. Then go to IDLE with `done`=1 for one cycle and `busy`=0.
- Baud counter counts 0..CLKS_PER_BIT-1; its width is clog2(CLKS_PER_BIT). Bit counter counts 0..WIDTH-1; its width is clog2(WIDTH).
- `en` deasserted mid-frame: the current frame completes; no new READ is issued.
- `empty` is ignored outside IDLE. Exactly one pop occurs per frame, so the block never underflows the FIFO.
- Reset asserted mid-frame: immediate return to reset values. The frame is truncated and the partial word is discarded; `tx` goes high the same instant.
- `read_en` is never asserted while `empty`=1 was sampled at the deciding edge.

## Timing
- Edge E0 samples `en`&~`empty` in IDLE. `read_en` is high during cycle E0..E1, LOAD occupies E1..E2, and `tx` falls at E2.
- Frame length on `tx`: (WIDTH+2)×CLKS_PER_BIT cycles. The default is 40 cycles.
- `done` rises at E2+(WIDTH+2)×CLKS_PER_BIT.
- Back-to-back frames with a non-empty FIFO: 3 idle-high cycles (IDLE, READ, LOAD) between a stop bit's end and the next start bit.
- Throughput: one word per (WIDTH+2)×CLKS_PER_BIT+3 cycles.

## Structure
- Shared package holds:
  - the state enum (IDLE, READ, LOAD, START, DATA, STOP);
  - default constants WIDTH=8 and CLKS_PER_BIT=4, shared with `sync_fifo`'s width constant.
- One sub-module, `bit_timer`: the baud counter.
  - Inputs: `clk`, `rst`, `clear`.
  - Output: `tick`, a one-cycle pulse when the count reaches CLKS_PER_BIT-1, after which the count wraps to 0.
- The FSM, bit counter and shift register live in `fifo_serial_tx`.

## Test plan
- Reset then idle with `empty`=1, `en`=1 for 100 cycles -> `tx` stays 1, `read_en`, `busy` and `done` stay 0.
- Single word 0xA5, `empty` drops at cycle 10 (CPB=4) -> `read_en` is pulsed for exactly one cycle. `tx` sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. `done` pulses 40 cycles after `tx` falls.
- Three words 0x00, 0xFF, 0x3C held non-empty -> three frames are sent in order, three `read_en` pulses occur, and there are exactly 3 high cycles between each stop bit's end and the next start bit.
- `en` dropped during the DATA bit 3 of 0x55 -> the frame completes correctly and no further `read_en` occurs while `empty`=0.
- `rst` pulsed low during DATA of 0x81 -> `tx`=1 and `busy`=0 immediately. After release with `empty`=0, a fresh frame is sent using the next FIFO word.
- CLKS_PER_BIT=2 build, word 0x01 -> each bit lasts 2 cycles and the frame is 20 cycles.

Source files
------------

// File: rtl/fifo_serial_tx_pkg.sv
// Shared types and default constants for the FIFO drain / serial transmitter.
package fifo_serial_tx_pkg;

  // Word width shared with sync_fifo; the transmitter defaults to the same value.
  localparam int FIFO_WIDTH       = 8;
  localparam int DEF_WIDTH        = FIFO_WIDTH;
  localparam int DEF_CLKS_PER_BIT = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

endpackage

// File: rtl/fifo_serial_tx_bit_timer.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
module bit_timer
  import fifo_serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Terminal-count compare; suppressed while the counter is being cleared.
  assign tick = (cnt == TC) && !clear;

  // Counter register: wraps to zero after the terminal count or on clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from sync_fifo and sends each as start + WIDTH data (LSB first) + stop.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line high, waiting for en & !empty
// S_READ  | read_en high for one cycle (FIFO pop)
// S_LOAD  | FIFO data becomes valid; captured on the leaving edge
// S_START | start bit (tx=0) for CLKS_PER_BIT cycles
// S_DATA  | WIDTH data bits, LSB first, CLKS_PER_BIT cycles each
// S_STOP  | stop bit (tx=1); leaving edge pulses done
module fifo_serial_tx
  import fifo_serial_tx_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             read_en,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  tx_state_e        state, state_nxt;
  logic [WIDTH-1:0] shift, shift_nxt;
  logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
  logic             read_en_nxt, tx_nxt, busy_nxt, done_nxt;
  logic             tick, timer_clear;

  // Baud counter restarts while LOAD so the start bit gets a full period.
  assign timer_clear = (state == S_LOAD);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .tick (tick)
  );

  // State and registered outputs; reset returns the line high immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      read_en <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
      read_en <= read_en_nxt;
      tx      <= tx_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Next-state and next-output decode; read_en and done are single-cycle strobes.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    read_en_nxt = 1'b0;
    tx_nxt      = tx;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        if (en && !empty) begin
          state_nxt   = S_READ;
          read_en_nxt = 1'b1;
          busy_nxt    = 1'b1;
        end
      end
      S_READ: begin
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        shift_nxt = fifo_data;
        tx_nxt    = 1'b0;
        state_nxt = S_START;
      end
      S_START: begin
        if (tick) begin
          tx_nxt      = shift[0];
          bit_cnt_nxt = '0;
          state_nxt   = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_nxt   = shift >> 1;
          bit_cnt_nxt = bit_cnt + BW'(1);
          if (bit_cnt == LAST_BIT) begin
            tx_nxt    = 1'b1;
            state_nxt = S_STOP;
          end else begin
            tx_nxt = shift[1];
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
